// File: rtl/tm_loader.sv
// tm_loader: turns a DATA / DONE / STEP command stream into timed presses of
// the Turing machine's Next and Done buttons, with the data word held on
// input_data.
//
// Build option: define TM_LOADER_STATS_EN to add the cmd_count / drop_count
// statistics outputs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command (in_ready may be 1)
// SETUP | one cycle with both buttons released before the press
// HIGH  | button held for PULSE_CYCLES cycles
// LOW   | button released for GAP_CYCLES cycles, then back to IDLE

module tm_loader #(
    parameter int AW           = 6,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [1:0]    in_kind,
    input  logic [AW-1:0] in_data,
    output logic          in_ready,
    input  logic          compute_done,
    output logic [AW-1:0] input_data,
    output logic          Next,
    output logic          Done,
    output logic          busy
`ifdef TM_LOADER_STATS_EN
    ,
    output logic [7:0]    cmd_count,
    output logic [7:0]    drop_count
`endif
);

    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   data_q, data_d;
    logic            is_done_q, is_done_d;
    logic            next_q, next_d;
    logic            done_q, done_d;
    logic            rdy_q, rdy_d;
    logic            accept;

    // Buttons and data word come straight from flops. in_ready drops on the
    // accept edge but only comes back one cycle after IDLE is re-entered, so
    // the outside view lines up with the one-cycle-late registered buttons.
    // While reset is held both in_ready and busy read 0.
    assign input_data = data_q;
    assign Next       = next_q;
    assign Done       = done_q;
    assign in_ready   = rdy_q & ~reset;
    assign busy       = ~rdy_q & ~reset;
    assign accept     = in_valid & rdy_q & (state_q == IDLE);

    // Next-state, counter, command latch and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        data_d    = data_q;
        is_done_d = is_done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (in_kind)
                        2'b00: begin
                            data_d    = in_data;
                            is_done_d = 1'b0;
                            state_d   = SETUP;
                        end
                        2'b01: begin
                            is_done_d = 1'b1;
                            state_d   = SETUP;
                        end
                        2'b10: begin
                            if (!compute_done) begin
                                is_done_d = 1'b0;
                                state_d   = SETUP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SETUP: state_d = HIGH;
            HIGH: begin
                if (cnt_q == PULSE_LAST) state_d = LOW;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            LOW: begin
                if (cnt_q == GAP_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        next_d = (state_q == HIGH) && !is_done_q;
        done_d = (state_q == HIGH) &&  is_done_q;
        rdy_d  = (state_q == IDLE) && (state_d == IDLE);
    end

    // State, counter and output registers; reset clears everything mid-pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            is_done_q <= 1'b0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            is_done_q <= is_done_d;
            next_q    <= next_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
        end
    end

`ifdef TM_LOADER_STATS_EN
    logic [7:0] cmd_q;
    logic [7:0] drop_q;
    logic       play;
    logic       drop;

    assign play       = (state_q == SETUP);
    assign drop       = accept & ((in_kind == 2'b11) | ((in_kind == 2'b10) & compute_done));
    assign cmd_count  = cmd_q;
    assign drop_count = drop_q;

    // Played-pulse and dropped-command counters, free-running with wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_q  <= 8'd0;
            drop_q <= 8'd0;
        end else begin
            if (play) cmd_q  <= cmd_q + 8'd1;
            if (drop) drop_q <= drop_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tm_loader.sv
// Testbench for tm_loader (PULSE_CYCLES=2, GAP_CYCLES=3, AW=6).
module tb_tm_loader;

    localparam int AW = 6;
    localparam int P  = 2;
    localparam int G  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_kind;
    logic [AW-1:0] in_data;
    logic          in_ready;
    logic          compute_done;
    logic [AW-1:0] input_data;
    logic          Next;
    logic          Done;
    logic          busy;
`ifdef TM_LOADER_STATS_EN
    logic [7:0]    cmd_count;
    logic [7:0]    drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: command timing from arithmetic on the accept edge.
    logic [AW-1:0] m_data;
    int            m_ps, m_pe, m_ready_at, m_accepts;
    bit            m_isdone, m_rdy;
    logic [7:0]    m_cmd, m_drop;

    tm_loader #(.AW(AW), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_kind      (in_kind),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .compute_done (compute_done),
        .input_data   (input_data),
        .Next         (Next),
        .Done         (Done),
        .busy         (busy)
`ifdef TM_LOADER_STATS_EN
        ,
        .cmd_count    (cmd_count),
        .drop_count   (drop_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_data     = '0;
        m_ps       = -100;
        m_pe       = -100;
        m_ready_at = 0;
        m_rdy      = 1'b1;
        m_isdone   = 1'b0;
        m_cmd      = 8'd0;
        m_drop     = 8'd0;
    endtask

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic tick();
        bit play;
        @(posedge clock);
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            if (in_valid && m_rdy) begin
                play = 1'b0;
                case (in_kind)
                    2'd0: begin m_data = in_data; m_isdone = 1'b0; play = 1'b1; end
                    2'd1: begin m_isdone = 1'b1; play = 1'b1; end
                    2'd2: begin
                        if (compute_done) m_drop++;
                        else begin m_isdone = 1'b0; play = 1'b1; end
                    end
                    default: m_drop++;
                endcase
                if (play) begin
                    m_ps       = cyc + 2;
                    m_pe       = cyc + 1 + P;
                    m_ready_at = cyc + 2 + P + G;
                    m_cmd++;
                    m_accepts++;
                end
            end
            m_rdy = (cyc >= m_ready_at);
        end
        @(negedge clock);
    endtask

    function automatic logic exp_next();
        return !reset && !m_isdone && cyc >= m_ps && cyc <= m_pe;
    endfunction

    function automatic logic exp_done();
        return !reset && m_isdone && cyc >= m_ps && cyc <= m_pe;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_kind = 2'd0; in_data = 6'h3F; compute_done = 1'b0;
        model_reset();
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (Next !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL reset_buttons got %b%b want 00", Next, Done); end
        n_checks++; if (input_data !== 6'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", input_data); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL release_busy got %b want 0", busy); end
`ifdef TM_LOADER_STATS_EN
        n_checks++; if (cmd_count !== 8'd0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", cmd_count, drop_count); end
`endif
    endtask

    task automatic test_data_latency();
        in_valid = 1'b1; in_kind = 2'd0; in_data = 6'h15;
        tick();
        in_valid = 1'b0;
        n_checks++; if (input_data !== 6'h15) begin n_fail++; $display("FAIL lat_data got %h want 15", input_data); end
        n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL lat_ready_accept got %b want 0", in_ready); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (Next !== logic'(k == 2 || k == 3)) begin n_fail++; $display("FAIL lat_next T+%0d got %b want %b", k, Next, k == 2 || k == 3); end
            n_checks++;
            if (in_ready !== logic'(k >= 7)) begin n_fail++; $display("FAIL lat_ready T+%0d got %b want %b", k, in_ready, k >= 7); end
        end
    endtask

    task automatic test_done_after_data();
        int done_hi, next_hi;
        in_valid = 1'b1; in_kind = 2'd0; in_data = 6'h07;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 20 && in_ready !== 1'b1; w++) tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL done_wait_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_kind = 2'd1; in_data = 6'h2C;
        tick();
        in_valid = 1'b0;
        done_hi = 0; next_hi = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (Done === 1'b1) done_hi++;
            if (Next === 1'b1) next_hi++;
        end
        n_checks++; if (done_hi != P)         begin n_fail++; $display("FAIL done_width got %0d want %0d", done_hi, P); end
        n_checks++; if (next_hi != 0)         begin n_fail++; $display("FAIL done_next got %0d want 0", next_hi); end
        n_checks++; if (input_data !== 6'h07) begin n_fail++; $display("FAIL done_data got %h want 07", input_data); end
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL done_ready got %b want 1", in_ready); end
    endtask

    task automatic test_step_dropped();
        int pulses;
        logic [7:0] cmd0, drop0;
        cmd0 = m_cmd; drop0 = m_drop;
        compute_done = 1'b1; in_valid = 1'b1; in_kind = 2'd2;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_step_ready got %b want 1", in_ready); end
`ifdef TM_LOADER_STATS_EN
        n_checks++; if (drop_count !== drop0 + 8'd1) begin n_fail++; $display("FAIL drop_step_count got %0d want %0d", drop_count, drop0 + 8'd1); end
`endif
        compute_done = 1'b0; in_kind = 2'd3;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_rsv_ready got %b want 1", in_ready); end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (Next === 1'b1 || Done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL drop_pulses got %0d want 0", pulses); end
        n_checks++; if (input_data !== 6'h07) begin n_fail++; $display("FAIL drop_data got %h want 07", input_data); end
`ifdef TM_LOADER_STATS_EN
        n_checks++; if (drop_count !== drop0 + 8'd2) begin n_fail++; $display("FAIL drop_count got %0d want %0d", drop_count, drop0 + 8'd2); end
        n_checks++; if (cmd_count !== cmd0) begin n_fail++; $display("FAIL drop_cmd got %0d want %0d", cmd_count, cmd0); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] q[$];
        logic [AW-1:0] words[3];
        int rises, low_run, acc0;
        logic prev;
        words = '{6'h11, 6'h22, 6'h33};
        foreach (words[i]) q.push_back(words[i]);
        rises = 0; low_run = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (q.size() > 0) begin in_valid = 1'b1; in_kind = 2'd0; in_data = q[0]; end
            else in_valid = 1'b0;
            acc0 = m_accepts;
            tick();
            if (m_accepts != acc0) void'(q.pop_front());
            n_checks++;
            if (Next !== exp_next()) begin n_fail++; $display("FAIL b2b_next cyc %0d got %b want %b", cyc, Next, exp_next()); end
            if (Next === 1'b1 && prev === 1'b0) begin
                n_checks++;
                if (rises < 3 && input_data !== words[rises]) begin n_fail++; $display("FAIL b2b_word %0d got %h want %h", rises, input_data, words[rises]); end
                if (rises > 0) begin
                    n_checks++;
                    if (low_run < G + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want >=%0d", low_run, G + 1); end
                end
                rises++;
            end
            low_run = (Next === 1'b1) ? 0 : low_run + 1;
            prev = Next;
        end
        in_valid = 1'b0;
        n_checks++; if (rises != 3)    begin n_fail++; $display("FAIL b2b_pulses got %0d want 3", rises); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_pending got %0d want 0", q.size()); end
    endtask

    task automatic test_compute_done_midpulse();
        int next_hi;
        compute_done = 1'b0; in_valid = 1'b1; in_kind = 2'd2;
        tick();
        in_valid = 1'b0; compute_done = 1'b1;
        next_hi = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (Next === 1'b1) next_hi++;
        end
        compute_done = 1'b0;
        n_checks++; if (next_hi != P)      begin n_fail++; $display("FAIL cd_width got %0d want %0d", next_hi, P); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cd_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_midpulse();
        in_valid = 1'b1; in_kind = 2'd0; in_data = 6'h2A;
        tick();
        in_valid = 1'b0;
        for (int w = 0; w < 20 && in_ready !== 1'b1; w++) tick();
        in_valid = 1'b1; in_kind = 2'd2; compute_done = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (Next !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_next got %b want 1", Next); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (Next !== 1'b0)        begin n_fail++; $display("FAIL rmid_next got %b want 0", Next); end
        n_checks++; if (input_data !== 6'h00) begin n_fail++; $display("FAIL rmid_data got %h want 00", input_data); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got busy %b ready %b want 0 0", busy, in_ready); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid     = ($urandom_range(0, 2) == 0);
            in_kind      = 2'($urandom_range(0, 3));
            in_data      = AW'($urandom);
            compute_done = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (Next !== exp_next() || Done !== exp_done()) begin
                n_fail++; $display("FAIL rnd_buttons cyc %0d got %b%b want %b%b", cyc, Next, Done, exp_next(), exp_done());
            end
            n_checks++;
            if (in_ready !== m_rdy || busy !== !m_rdy) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d got %b/%b want %b/%b", cyc, in_ready, busy, m_rdy, !m_rdy);
            end
            n_checks++;
            if (input_data !== m_data) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, input_data, m_data); end
        end
        in_valid = 1'b0; compute_done = 1'b0;
        repeat (10) tick();
`ifdef TM_LOADER_STATS_EN
        n_checks++;
        if (cmd_count !== m_cmd || drop_count !== m_drop) begin
            n_fail++; $display("FAIL rnd_stats got %0d/%0d want %0d/%0d", cmd_count, drop_count, m_cmd, m_drop);
        end
`endif
    endtask

`ifdef TM_LOADER_STATS_EN
    task automatic test_wrap();
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; w < 20 && in_ready !== 1'b1; w++) tick();
            in_valid = 1'b1; in_kind = 2'd0; in_data = AW'(i);
            tick();
            in_valid = 1'b0;
            if (i == 254) begin
                repeat (3) tick();
                n_checks++; if (cmd_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", cmd_count); end
            end
        end
        repeat (3) tick();
        n_checks++; if (cmd_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got %0d want 0", cmd_count); end
    endtask
`endif

    initial begin
        m_accepts = 0;
        test_reset();
        test_data_latency();
        test_done_after_data();
        test_step_dropped();
        test_back_to_back();
        test_compute_done_midpulse();
        test_reset_midpulse();
        test_random();
`ifdef TM_LOADER_STATS_EN
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
